// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the fetch front end.
package fetch_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int OPC_W_DEF  = 4;
    localparam int OPR_W_DEF  = 4;
    localparam int DEPTH_DEF  = 4;

    localparam logic [OPC_W_DEF-1:0] HALT_OPC_DEF = 4'hF;

    // One prefetched instruction: its fetch address plus the split memory word.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [OPC_W_DEF-1:0]  opc;
        logic [OPR_W_DEF-1:0]  opr;
    } fetch_entry_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head word reads as zero while empty.
module fetch_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the head slot in the same edge, so a full FIFO may still take a push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale words never escape.
    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : store[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, program-memory port and prefetch queue.
// Optional halt-opcode detection is enabled by defining FETCH_QUEUE_HALT_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 OPC_W    = OPC_W_DEF,
    parameter int                 OPR_W    = OPR_W_DEF,
    parameter int                 DEPTH    = DEPTH_DEF,
    parameter logic [OPC_W-1:0]   HALT_OPC = HALT_OPC_DEF,
    localparam int                CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   jump,
    input  logic [ADDR_W-1:0]      jump_addr,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [OPC_W+OPR_W-1:0] mem_data,
    output logic [OPC_W-1:0]       instr,
    output logic [OPR_W-1:0]       operand,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic                   valid,
    input  logic                   ready,
    output logic [CNT_W-1:0]       count,
    output logic                   halted
);

    localparam int WORD_W  = OPC_W + OPR_W;
    localparam int ENTRY_W = ADDR_W + WORD_W;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0]  pc;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;
    logic               advance;
    logic               full;
    logic               empty;

    assign mem_addr = pc;
    assign valid    = !empty;
    assign pop      = valid && ready;
    // Jump never pushes: the word on mem_data belongs to the path being abandoned.
    assign push     = enable && !halted && !jump && (!full || pop);

`ifdef FETCH_QUEUE_HALT_EN
    logic halt_hit;
    logic halt_q;

    assign halt_hit = (mem_data[WORD_W-1:OPR_W] == HALT_OPC);
    assign advance  = push && !halt_hit;
    assign halted   = halt_q;

    always_ff @(posedge clk) begin
        if (reset || jump) begin
            halt_q <= 1'b0;
        end else if (push && halt_hit) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign advance = push;
    assign halted  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (jump) begin
            pc <= jump_addr;
        end else if (advance) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (jump),
        .wr_data ({pc, mem_data}),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign instr_pc = head[ENTRY_W-1:WORD_W];
    assign instr    = head[WORD_W-1:OPR_W];
    assign operand  = head[OPR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        jump;
    logic [11:0] jump_addr;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic [11:0] instr_pc;
    logic        valid;
    logic        ready;
    logic [2:0]  count;
    logic        halted;

    logic [7:0]   prog [4096];
    fetch_entry_t sb [$];
    int           checks   = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    assign mem_data = prog[mem_addr];

    fetch_queue dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .instr     (instr),
        .operand   (operand),
        .instr_pc  (instr_pc),
        .valid     (valid),
        .ready     (ready),
        .count     (count),
        .halted    (halted)
    );

    // Program image never contains opcode F unless a test plants it.
    function automatic logic [7:0] word(input logic [11:0] a);
        return {1'b0, a[6:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic expect_entry(input logic [11:0] a, input logic [7:0] d);
        fetch_entry_t e;
        e.pc  = a;
        e.opc = d[7:4];
        e.opr = d[3:0];
        sb.push_back(e);
    endtask

    task automatic expect_run(input logic [11:0] first, input int n);
        logic [11:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            expect_entry(a, word(a));
            a = a + 12'd1;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (sb.size() == 0) begin
                check("unexpected_entry_pc", {20'd0, instr_pc}, 32'hFFFF_FFFF);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                check("head_pc",      {20'd0, instr_pc}, {20'd0, e.pc});
                check("head_opcode",  {28'd0, instr},    {28'd0, e.opc});
                check("head_operand", {28'd0, operand},  {28'd0, e.opr});
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) prog[i] = word(12'(i));
        reset = 1'b1; enable = 1'b0; ready = 1'b0; jump = 1'b0; jump_addr = '0;
        tick(2);
        check("rst_valid",    {31'd0, valid},    0);
        check("rst_count",    {29'd0, count},    0);
        check("rst_mem_addr", {20'd0, mem_addr}, 0);
        check("rst_instr",    {28'd0, instr},    0);
        check("rst_operand",  {28'd0, operand},  0);
        check("rst_instr_pc", {20'd0, instr_pc}, 0);
        check("rst_halted",   {31'd0, halted},   0);

        // Streaming from reset: one instruction per cycle.
        reset = 1'b0; enable = 1'b1; ready = 1'b1;
        expect_run(12'h000, 10);
        tick();
        check("first_valid",    {31'd0, valid},    1);
        check("first_instr_pc", {20'd0, instr_pc}, 0);
        check("first_count",    {29'd0, count},    1);
        check("first_mem_addr", {20'd0, mem_addr}, 1);
        tick(9);
        check("stream_mem_addr", {20'd0, mem_addr}, 10);
        check("stream_count",    {29'd0, count},    1);
        enable = 1'b0;
        tick();
        check("stream_drained", {29'd0, count}, 0);

        // PC wrap 0xFFF -> 0x000.
        jump = 1'b1; jump_addr = 12'hFFD;
        tick();
        jump = 1'b0;
        check("wrap_jump_addr", {20'd0, mem_addr}, 32'hFFD);
        enable = 1'b1;
        expect_run(12'hFFD, 5);
        tick(5);
        check("wrap_mem_addr", {20'd0, mem_addr}, 2);
        enable = 1'b0;
        tick();

        // Back-pressure, then full queue with push and pop on the same edge.
        jump = 1'b1; jump_addr = 12'h000;
        tick();
        jump = 1'b0; ready = 1'b0; enable = 1'b1;
        expect_run(12'h000, 8);
        tick(6);
        check("full_count",    {29'd0, count},    4);
        check("full_mem_addr", {20'd0, mem_addr}, 4);
        check("full_head_pc",  {20'd0, instr_pc}, 0);
        ready = 1'b1;
        tick();
        check("pushpop_count",    {29'd0, count},    4);
        check("pushpop_head_pc",  {20'd0, instr_pc}, 1);
        check("pushpop_mem_addr", {20'd0, mem_addr}, 5);
        tick(3);
        check("pushpop_count_b",  {29'd0, count},    4);
        enable = 1'b0;
        tick(4);
        check("bp_drained", {29'd0, count}, 0);

        // Jump with three queued entries: the head is accepted on the jump edge, the rest vanish.
        ready = 1'b0; enable = 1'b1;
        tick(3);
        check("prejump_count", {29'd0, count}, 3);
        expect_entry(12'h008, word(12'h008));
        jump = 1'b1; jump_addr = 12'h100; ready = 1'b1;
        tick();
        jump = 1'b0;
        check("jump_count",    {29'd0, count},    0);
        check("jump_valid",    {31'd0, valid},    0);
        check("jump_mem_addr", {20'd0, mem_addr}, 32'h100);
        expect_run(12'h100, 3);
        tick();
        check("postjump_valid",   {31'd0, valid},    1);
        check("postjump_head_pc", {20'd0, instr_pc}, 32'h100);
        tick(2);
        enable = 1'b0;
        tick();

        // Halt opcode planted at address 5.
        prog[5] = 8'hF0;
        jump = 1'b1; jump_addr = 12'h000;
        tick();
        jump = 1'b0; enable = 1'b1; ready = 1'b1;
        expect_run(12'h000, 5);
        expect_entry(12'h005, 8'hF0);
`ifdef FETCH_QUEUE_HALT_EN
        tick(6);
        check("halt_flag",     {31'd0, halted},   1);
        check("halt_mem_addr", {20'd0, mem_addr}, 5);
        tick(3);
        check("halt_count",    {29'd0, count},    0);
        check("halt_valid",    {31'd0, valid},    0);
        check("halt_pc_held",  {20'd0, mem_addr}, 5);
`else
        expect_run(12'h006, 3);
        tick(6);
        check("nohalt_flag",     {31'd0, halted},   0);
        check("nohalt_mem_addr", {20'd0, mem_addr}, 6);
        tick(3);
        check("nohalt_mem_addr_b", {20'd0, mem_addr}, 9);
`endif
        jump = 1'b1; jump_addr = 12'h020;
        tick();
        jump = 1'b0;
        check("resume_halted",   {31'd0, halted},   0);
        check("resume_mem_addr", {20'd0, mem_addr}, 32'h020);
        expect_run(12'h020, 2);
        tick(2);
        enable = 1'b0;
        tick();
        prog[5] = word(12'h005);

        // Reset mid-stream with three entries held.
        ready = 1'b0; enable = 1'b1;
        tick(3);
        check("prerst_count", {29'd0, count}, 3);
        reset = 1'b1;
        tick();
        check("midrst_valid",    {31'd0, valid},    0);
        check("midrst_count",    {29'd0, count},    0);
        check("midrst_mem_addr", {20'd0, mem_addr}, 0);
        check("midrst_instr",    {28'd0, instr},    0);
        check("midrst_operand",  {28'd0, operand},  0);
        check("midrst_instr_pc", {20'd0, instr_pc}, 0);
        reset = 1'b0; enable = 1'b0;
        tick(2);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
